jts16_adc_mux: RTL and testbench

Parametrised multi-channel analog-input converter for the S16/Out Run family cabinets. It models the cabinet ADC: a CPU write snapshots every analog input, then converts the selected channel after a programmable number of CPU clock-enable ticks. During conversion it applies a per-channel transfer mode (centred wheel, gas half-axis, brake half-axis or raw) and digital-button override. It sits on the main CPU I/O decode, replacing the fixed 3–4 channel inline ADC logic.

---
 rtl/jts16_adc_mux.sv | 97 +++++++++
 tb/tb_jts16_adc_mux.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/jts16_adc_mux.sv
// jts16_adc_mux: multi-channel cabinet ADC model that snapshots all inputs on start
// and converts the latched channel after CONV cen ticks, with per-channel transfer modes.
module jts16_adc_mux #(
  parameter int         CH    = 4,
  parameter int         CONV  = 8,
  parameter logic [7:0] OVR_A = 8'h20,
  parameter logic [7:0] OVR_B = 8'hD0,
  parameter logic [7:0] OVR_P = 8'hF0,
  localparam int        CHW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            sel_we,
  input  logic [2:0]      sel_din,
  input  logic            start,
  input  logic [CH*16-1:0] ana,
  input  logic [CH*2-1:0] ch_mode,
  input  logic [CH*2-1:0] ovr_n,
  output logic [7:0]      dout,
  output logic            busy,
  output logic            eoc,
  output logic [CHW-1:0]  ch
);
  localparam int CW = $clog2(CONV + 1);
  typedef enum logic {ST_IDLE, ST_CONV} state_t;
  state_t r_state, w_nstate;
  logic [CH*16-1:0] r_ana;
  logic [CH*2-1:0]  r_mode, r_ovr;
  logic [CHW-1:0]   r_cch, r_ch;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_dout, w_res;
  logic             r_eoc, w_load, w_done, w_hit, w_any;
  logic [15:0]      w_v;
  logic [1:0]       w_m, w_o;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_ana   <= '0;
      r_mode  <= '0;
      r_ovr   <= '0;
      r_cch   <= '0;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_dout  <= 8'hFF;
      r_eoc   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_eoc   <= w_done;
      if (sel_we) r_ch <= sel_din[CHW-1:0];
      if (w_load) begin
        r_ana  <= ana;
        r_mode <= ch_mode;
        r_ovr  <= ovr_n;
        r_cch  <= r_ch;
        r_cnt  <= CW'(CONV);
      end else if (r_state == ST_CONV && cen) r_cnt <= r_cnt - 1'b1;
      if (w_done) r_dout <= w_res;
    end
  // start always wins, so a cen in the same cycle is never counted
  always_comb begin
    w_nstate = r_state;
    w_load   = 1'b0;
    w_done   = 1'b0;
    if (start) begin
      w_nstate = ST_CONV;
      w_load   = 1'b1;
    end else if (r_state == ST_CONV && cen && r_cnt == CW'(1)) begin
      w_nstate = ST_IDLE;
      w_done   = 1'b1;
    end
  end
  always_comb begin
    w_v   = '0;
    w_m   = '0;
    w_o   = 2'b11;
    w_hit = 1'b0;
    for (int i = 0; i < CH; i++)
      if (r_cch == CHW'(i)) begin
        w_v   = r_ana[16*i +: 16];
        w_m   = r_mode[2*i +: 2];
        w_o   = r_ovr[2*i +: 2];
        w_hit = 1'b1;
      end
    w_any = ~&w_o;
    w_res = !w_hit ? 8'hFF :
            w_m == 2'd0 ? (!w_o[0] ? OVR_A : !w_o[1] ? OVR_B : w_v[7:0] ^ 8'h80) :
            w_m == 2'd3 ? w_v[15:8] :
            w_any ? OVR_P :
            w_m == 2'd1 ? (w_v[15] ? ~{w_v[14:8], w_v[14]} : 8'h00) :
                          (w_v[15] ? 8'h00 : {w_v[14:8], w_v[14]});
  end
  assign dout = r_dout;
  assign busy = r_state == ST_CONV;
  assign eoc  = r_eoc;
  assign ch   = r_ch;
endmodule

// File: tb/tb_jts16_adc_mux.sv
// tb_jts16_adc_mux: directed checks of conversion timing, transfer modes, snapshot,
// restart, out-of-range channel and asynchronous reset.
module tb_jts16_adc_mux;
  localparam int CH = 3, CONV = 8;
  logic clk, rst, cen, sel_we, start;
  logic [2:0] sel_din;
  logic [CH*16-1:0] ana;
  logic [CH*2-1:0] ch_mode, ovr_n;
  logic [7:0] dout;
  logic busy, eoc;
  logic [1:0] ch;
  int n_chk = 0, n_pass = 0, eoc_cnt = 0;

  jts16_adc_mux #(.CH(CH), .CONV(CONV)) dut (
    .clk(clk), .rst(rst), .cen(cen), .sel_we(sel_we), .sel_din(sel_din),
    .start(start), .ana(ana), .ch_mode(ch_mode), .ovr_n(ovr_n),
    .dout(dout), .busy(busy), .eoc(eoc), .ch(ch)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (eoc) eoc_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input logic [2:0] v);
    sel_din = v;
    sel_we = 1;
    tick();
    sel_we = 0;
  endtask

  task automatic pulse_cen(input int n);
    for (int i = 0; i < n; i++) begin
      cen = 1;
      tick();
      cen = 0;
      tick();
    end
  endtask

  // runs one full conversion, spacing cen ticks with idle cycles
  task automatic run_conv(output logic [7:0] d, output int n_eoc, output bit bw, output bit done_ok);
    int e0;
    e0 = eoc_cnt;
    bw = 1;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < CONV; i++) begin
      if (!busy) bw = 0;
      cen = 1;
      tick();
      cen = 0;
      if (i < CONV - 1) begin
        if (!busy || eoc) bw = 0;
        tick();
      end
    end
    done_ok = !busy && eoc;
    d = dout;
    tick();
    n_eoc = eoc_cnt - e0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    n_chk++; if (dout !== 8'hFF) $display("FAIL reset_dout got %h want ff", dout); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (eoc !== 1'b0) $display("FAIL reset_eoc got %b want 0", eoc); else n_pass++;
    n_chk++; if (ch !== 2'd0) $display("FAIL reset_ch got %0d want 0", ch); else n_pass++;
    rst = 0;
    tick();
  endtask

  task automatic test_wheel();
    logic [1:0] o_tab [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    logic [7:0] e_tab [4] = '{8'h90, 8'h20, 8'hD0, 8'h20};
    logic [7:0] d; int n; bit bw, ok;
    set_ch(0);
    ch_mode = '0;
    ana[15:0] = 16'h0010;
    for (int k = 0; k < 4; k++) begin
      ovr_n = '1;
      ovr_n[1:0] = o_tab[k];
      run_conv(d, n, bw, ok);
      n_chk++; if (d !== e_tab[k]) $display("FAIL wheel_%0d dout got %h want %h", k, d, e_tab[k]); else n_pass++;
      n_chk++; if (n !== 1) $display("FAIL wheel_eoc_%0d got %0d want 1", k, n); else n_pass++;
      n_chk++; if (!(bw && ok)) $display("FAIL wheel_timing_%0d busy_window %0b done %0b want 1 1", k, bw, ok); else n_pass++;
    end
  endtask

  task automatic test_gas_brake();
    logic [15:0] a_tab [3] = '{16'hA000, 16'h2000, 16'hA000};
    logic [3:0]  o_tab [3] = '{4'b1111, 4'b1111, 4'b0110};
    logic [7:0]  g_tab [3] = '{8'hBF, 8'h00, 8'hF0};
    logic [7:0]  b_tab [3] = '{8'h00, 8'h40, 8'hF0};
    logic [7:0] d; int n; bit bw, ok;
    ch_mode = 6'b10_01_00;
    for (int k = 0; k < 3; k++) begin
      ana[31:16] = a_tab[k];
      ana[47:32] = a_tab[k];
      ovr_n = {o_tab[k], 2'b11};
      set_ch(1);
      run_conv(d, n, bw, ok);
      n_chk++; if (d !== g_tab[k]) $display("FAIL gas_%0d dout got %h want %h", k, d, g_tab[k]); else n_pass++;
      set_ch(2);
      run_conv(d, n, bw, ok);
      n_chk++; if (d !== b_tab[k]) $display("FAIL brake_%0d dout got %h want %h", k, d, b_tab[k]); else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    int e0;
    set_ch(0);
    ch_mode = '0;
    ovr_n = '1;
    ana[15:0] = 16'h0010;
    e0 = eoc_cnt;
    start = 1;
    tick();
    start = 0;
    pulse_cen(2);
    ana[15:0] = 16'h0033;
    set_ch(2);
    pulse_cen(CONV - 2);
    n_chk++; if (dout !== 8'h90) $display("FAIL snap_dout got %h want 90", dout); else n_pass++;
    n_chk++; if (ch !== 2'd2) $display("FAIL snap_ch got %0d want 2", ch); else n_pass++;
    n_chk++; if (eoc_cnt - e0 !== 1) $display("FAIL snap_eoc got %0d want 1", eoc_cnt - e0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e0;
    bit bw;
    set_ch(0);
    ana[15:0] = 16'h0010;
    e0 = eoc_cnt;
    start = 1;
    tick();
    start = 0;
    pulse_cen(5);
    ana[15:0] = 16'h0005;
    start = 1;
    cen = 1;
    sel_din = 3'd1;
    sel_we = 1;
    tick();
    start = 0;
    cen = 0;
    sel_we = 0;
    n_chk++; if (ch !== 2'd1) $display("FAIL restart_ch got %0d want 1", ch); else n_pass++;
    bw = 1;
    for (int i = 0; i < CONV - 1; i++) begin
      pulse_cen(1);
      if (!busy) bw = 0;
    end
    n_chk++; if (!bw || eoc_cnt != e0) $display("FAIL restart_early busy %0b eocs %0d want 1 0", bw, eoc_cnt - e0); else n_pass++;
    pulse_cen(1);
    n_chk++; if (busy !== 1'b0) $display("FAIL restart_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (dout !== 8'h85) $display("FAIL restart_dout got %h want 85", dout); else n_pass++;
    n_chk++; if (eoc_cnt - e0 !== 1) $display("FAIL restart_eoc got %0d want 1", eoc_cnt - e0); else n_pass++;
  endtask

  task automatic test_oor_raw();
    logic [7:0] d; int n; bit bw, ok;
    set_ch(3'd5);
    n_chk++; if (ch !== 2'd1) $display("FAIL sel_trunc got %0d want 1", ch); else n_pass++;
    set_ch(3'd3);
    run_conv(d, n, bw, ok);
    n_chk++; if (d !== 8'hFF) $display("FAIL oor_dout got %h want ff", d); else n_pass++;
    n_chk++; if (n !== 1) $display("FAIL oor_eoc got %0d want 1", n); else n_pass++;
    set_ch(0);
    ch_mode[1:0] = 2'd3;
    ana[15:0] = 16'hAB12;
    ovr_n[1:0] = 2'b00;
    run_conv(d, n, bw, ok);
    n_chk++; if (d !== 8'hAB) $display("FAIL raw_dout got %h want ab", d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = eoc_cnt;
    ana[15:0] = 16'h1234;
    start = 1;
    tick();
    start = 0;
    pulse_cen(3);
    #2 rst = 1;
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (dout !== 8'hFF) $display("FAIL rstmid_dout got %h want ff", dout); else n_pass++;
    n_chk++; if (ch !== 2'd0) $display("FAIL rstmid_ch got %0d want 0", ch); else n_pass++;
    tick();
    rst = 0;
    pulse_cen(CONV + 2);
    n_chk++; if (eoc_cnt != e0 || busy) $display("FAIL rstmid_eoc eocs %0d busy %b want 0 0", eoc_cnt - e0, busy); else n_pass++;
  endtask

  initial begin
    rst = 1; cen = 0; sel_we = 0; start = 0; sel_din = 0;
    ana = '0; ch_mode = '0; ovr_n = '1;
    test_reset();
    test_wheel();
    test_gas_brake();
    test_snapshot();
    test_back_to_back();
    test_oor_raw();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
